// File: rtl/override_reg.sv
// Datapath holding register with force/release override; 1-cycle latency for data and force.
// Release returns q to the datapath (wire-like) or keeps the forced value (reg-like) per RELEASE_MODE.
module override_reg #(
  parameter int WIDTH        = 5,
  parameter int RELEASE_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_in,
  input  logic             d_valid,
  input  logic             frc_req,
  input  logic [WIDTH-1:0] frc_val,
  input  logic [7:0]       frc_cycles,
  input  logic             rel_req,
  output logic [WIDTH-1:0] q,
  output logic             forced,
  output logic             frc_ack,
  output logic             rel_pulse
);

  typedef enum logic {IDLE, FORCED} state_t;

  state_t           state;
  logic [WIDTH-1:0] shadow;
  logic [7:0]       cnt;
  logic             infinite;
  logic             release_now;

  assign release_now = rel_req || (!infinite && cnt == 8'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      q         <= '0;
      shadow    <= '0;
      cnt       <= '0;
      infinite  <= 1'b0;
      forced    <= 1'b0;
      frc_ack   <= 1'b0;
      rel_pulse <= 1'b0;
    end else begin
      frc_ack   <= 1'b0;
      rel_pulse <= 1'b0;
      // Shadow tracks the datapath even while the output is overridden.
      if (d_valid) shadow <= d_in;
      case (state)
        IDLE: begin
          if (frc_req) begin
            state    <= FORCED;
            forced   <= 1'b1;
            frc_ack  <= 1'b1;
            q        <= frc_val;
            cnt      <= frc_cycles;
            infinite <= (frc_cycles == 8'd0);
          end else if (d_valid) begin
            q <= d_in;
          end
        end
        FORCED: begin
          if (release_now) begin
            state     <= IDLE;
            forced    <= 1'b0;
            rel_pulse <= 1'b1;
            cnt       <= '0;
            infinite  <= 1'b0;
            if (d_valid) q <= d_in;
            else if (RELEASE_MODE == 0) q <= shadow;
          end else if (frc_req) begin
            frc_ack  <= 1'b1;
            q        <= frc_val;
            cnt      <= frc_cycles;
            infinite <= (frc_cycles == 8'd0);
          end else if (!infinite) begin
            cnt <= cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_override_reg.sv
// Scoreboard bench for override_reg: both release modes driven in lockstep, expectations queued per edge.
module tb_override_reg;

  typedef struct packed {
    logic [4:0] q;
    logic       forced;
    logic       ack;
    logic       rel;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] d_in;
  logic       d_valid;
  logic       frc_req;
  logic [4:0] frc_val;
  logic [7:0] frc_cycles;
  logic       rel_req;

  logic [4:0] q0, q1;
  logic       f0, f1, a0, a1, r0, r1;

  obs_t sb0[$];
  obs_t sb1[$];
  obs_t exp0, exp1, act0, act1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  override_reg #(.WIDTH(5), .RELEASE_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .d_in(d_in), .d_valid(d_valid), .frc_req(frc_req),
    .frc_val(frc_val), .frc_cycles(frc_cycles), .rel_req(rel_req),
    .q(q0), .forced(f0), .frc_ack(a0), .rel_pulse(r0)
  );

  override_reg #(.WIDTH(5), .RELEASE_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .d_in(d_in), .d_valid(d_valid), .frc_req(frc_req),
    .frc_val(frc_val), .frc_cycles(frc_cycles), .rel_req(rel_req),
    .q(q1), .forced(f1), .frc_ack(a1), .rel_pulse(r1)
  );

  function automatic obs_t o(input int qv, input logic f, input logic a, input logic r);
    obs_t t;
    t.q = qv[4:0];
    t.forced = f;
    t.ack = a;
    t.rel = r;
    return t;
  endfunction

  // Monitor: every presented cycle with a pending expectation is compared.
  always @(negedge clk) begin
    act0 = {q0, f0, a0, r0};
    act1 = {q1, f1, a1, r1};
    if (sb0.size() > 0) begin
      exp0 = sb0.pop_front();
      checks++;
      if (act0 !== exp0) begin
        errors++;
        $display("FAIL mode0 t=%0t got q=%0d forced=%b ack=%b rel=%b want q=%0d forced=%b ack=%b rel=%b",
                 $time, act0.q, act0.forced, act0.ack, act0.rel, exp0.q, exp0.forced, exp0.ack, exp0.rel);
      end
    end
    if (sb1.size() > 0) begin
      exp1 = sb1.pop_front();
      checks++;
      if (act1 !== exp1) begin
        errors++;
        $display("FAIL mode1 t=%0t got q=%0d forced=%b ack=%b rel=%b want q=%0d forced=%b ack=%b rel=%b",
                 $time, act1.q, act1.forced, act1.ack, act1.rel, exp1.q, exp1.forced, exp1.ack, exp1.rel);
      end
    end
  end

  // Apply inputs for one edge, then queue the outputs expected after that edge.
  task automatic cyc(input logic [4:0] d, input logic v, input logic fr, input logic [4:0] fv,
                     input logic [7:0] fc, input logic rl, input logic rs,
                     input obs_t e0, input obs_t e1);
    d_in = d; d_valid = v; frc_req = fr; frc_val = fv; frc_cycles = fc; rel_req = rl; rst = rs;
    @(posedge clk);
    #1;
    sb0.push_back(e0);
    sb1.push_back(e1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    d_in = 0; d_valid = 0; frc_req = 0; frc_val = 0; frc_cycles = 0; rel_req = 0; rst = 1;
    // Reset, then plain datapath
    cyc(7, 1, 1, 9, 3, 0, 1, o(0,0,0,0), o(0,0,0,0));
    cyc(7, 1, 0, 0, 0, 0, 1, o(0,0,0,0), o(0,0,0,0));
    cyc(6, 1, 0, 0, 0, 0, 0, o(6,0,0,0), o(6,0,0,0));
    cyc(9, 0, 0, 0, 0, 0, 0, o(6,0,0,0), o(6,0,0,0));
    // Timed force K=5; datapath update mid-force lands only in shadow
    cyc(0, 0, 1, 10, 5, 0, 0, o(10,1,1,0), o(10,1,1,0));
    cyc(0, 0, 0, 0, 0, 0, 0, o(10,1,0,0), o(10,1,0,0));
    cyc(0, 0, 0, 0, 0, 0, 0, o(10,1,0,0), o(10,1,0,0));
    cyc(15, 1, 0, 0, 0, 0, 0, o(10,1,0,0), o(10,1,0,0));
    cyc(0, 0, 0, 0, 0, 0, 0, o(10,1,0,0), o(10,1,0,0));
    cyc(0, 0, 0, 0, 0, 0, 0, o(15,0,0,1), o(10,0,0,1));
    cyc(0, 0, 0, 0, 0, 0, 0, o(15,0,0,0), o(10,0,0,0));
    cyc(15, 1, 0, 0, 0, 0, 0, o(15,0,0,0), o(15,0,0,0));
    // Indefinite force held 52 cycles, then explicit release
    cyc(0, 0, 1, 11, 0, 0, 0, o(11,1,1,0), o(11,1,1,0));
    for (int i = 0; i < 52; i++)
      cyc(20, 1, 0, 0, 0, 0, 0, o(11,1,0,0), o(11,1,0,0));
    cyc(0, 0, 0, 0, 0, 1, 0, o(20,0,0,1), o(11,0,0,1));
    cyc(0, 0, 0, 0, 0, 0, 0, o(20,0,0,0), o(11,0,0,0));
    // frc_req+rel_req in IDLE: force accepted; in FORCED: release wins, no ack
    cyc(0, 0, 1, 4, 0, 1, 0, o(4,1,1,0), o(4,1,1,0));
    cyc(0, 0, 1, 7, 3, 1, 0, o(20,0,0,1), o(4,0,0,1));
    // Re-force mid-force with val 3, K=2
    cyc(0, 0, 1, 9, 6, 0, 0, o(9,1,1,0), o(9,1,1,0));
    cyc(0, 0, 0, 0, 0, 0, 0, o(9,1,0,0), o(9,1,0,0));
    cyc(0, 0, 1, 3, 2, 0, 0, o(3,1,1,0), o(3,1,1,0));
    cyc(0, 0, 0, 0, 0, 0, 0, o(3,1,0,0), o(3,1,0,0));
    cyc(0, 0, 0, 0, 0, 0, 0, o(20,0,0,1), o(3,0,0,1));
    // K=1 force; d_valid in release cycle wins in both modes
    cyc(0, 0, 1, 1, 1, 0, 0, o(1,1,1,0), o(1,1,1,0));
    cyc(13, 1, 0, 0, 0, 0, 0, o(13,0,0,1), o(13,0,0,1));
    // Back-to-back re-force acks every cycle, no expiry
    for (int i = 0; i < 4; i++)
      cyc(0, 0, 1, 5, 2, 0, 0, o(5,1,1,0), o(5,1,1,0));
    cyc(0, 0, 0, 0, 0, 0, 0, o(5,1,0,0), o(5,1,0,0));
    cyc(0, 0, 0, 0, 0, 0, 0, o(13,0,0,1), o(5,0,0,1));
    // Reset mid-force: no rel_pulse, shadow cleared
    cyc(0, 0, 1, 22, 0, 0, 0, o(22,1,1,0), o(22,1,1,0));
    cyc(0, 0, 0, 0, 0, 0, 0, o(22,1,0,0), o(22,1,0,0));
    cyc(0, 0, 0, 0, 0, 0, 1, o(0,0,0,0), o(0,0,0,0));
    cyc(0, 0, 0, 0, 0, 0, 0, o(0,0,0,0), o(0,0,0,0));
    cyc(0, 0, 1, 2, 1, 0, 0, o(2,1,1,0), o(2,1,1,0));
    cyc(0, 0, 0, 0, 0, 0, 0, o(0,0,0,1), o(2,0,0,1));
    cyc(0, 0, 0, 0, 0, 0, 0, o(0,0,0,0), o(2,0,0,0));
    @(negedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
